// File: rtl/mem_port_arbiter.sv
// Arbitrates the single cache_mem port between instruction fetch (IF) and data (D) requesters.
// Latency: gnt is combinational in IDLE; response MEM_LAT+1 cycles after gnt for reads, 2 cycles for writes.
// Backpressure: one access in flight; requests are held by the requester and not granted until the FSM is back in IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int D_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              owner_q;     // 1 = D, 0 = IF
    logic              last_owner;  // 1 = D, 0 = IF
    logic              pick_d;
    logic              grant;
    logic              last_beat;

    // Winner selection; a grant is withheld while reset is high so no requester sees an accept that is dropped.
    always_comb begin
        pick_d = 1'b0;
        if (d_req && !if_req) begin
            pick_d = 1'b1;
        end else if (d_req && if_req) begin
            pick_d = (D_PRIORITY != 0) ? 1'b1 : !last_owner;
        end
        grant     = (state == IDLE) && (if_req || d_req) && !reset;
        last_beat = (cnt == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: writes leave ACCESS after one cycle, reads after the count expires.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  if (we_q || last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state and latched access attributes.
    always_comb begin
        if_gnt    = grant && !pick_d;
        d_gnt     = grant && pick_d;
        mem_read  = (state == ACCESS) && !we_q;
        mem_write = (state == ACCESS) && we_q;
        if_rvalid = (state == RESP) && !owner_q;
        d_rvalid  = (state == RESP) && owner_q;
        busy      = (state != IDLE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

    // Access latch, latency counter and response data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            rdata      <= '0;
        end else begin
            if (grant) begin
                addr_q     <= pick_d ? d_addr : if_addr;
                wdata_q    <= pick_d ? d_wdata : '0;
                we_q       <= pick_d && d_we;
                owner_q    <= pick_d;
                last_owner <= pick_d;
                cnt        <= CNT_W'(MEM_LAT);
            end else if (state == ACCESS) begin
                cnt <= cnt - CNT_W'(1);
                if (!we_q && last_beat) begin
                    rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
